// File: rtl/hc595_receiver.sv
// hc595_receiver: receiving end of the three-wire 74HC595 link.
// The sh_cp / st_cp / ds pins are resynchronized into clk through equal-depth
// chains so ds stays aligned with the shift clock. ds is shifted in MSB-first
// on each sh_cp rise, and the word is latched on each st_cp rise.
module hc595_receiver #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sh_cp,
  input  logic             st_cp,
  input  logic             ds,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic [7:0]       frame_cnt
);

  // The bit counter is wide enough to tell "exactly WIDTH" apart from
  // "more than WIDTH". It saturates so a very long frame never aliases
  // back to WIDTH.
  localparam int                CNT_W     = $clog2(WIDTH) + 2;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] sh_sync;
  logic [SYNC_STAGES-1:0] st_sync;
  logic [SYNC_STAGES-1:0] ds_sync;
  logic                   sh_prev;
  logic                   st_prev;
  logic                   sh_s;
  logic                   st_s;
  logic                   ds_s;
  logic                   sh_rise;
  logic                   st_rise;

  logic [WIDTH-1:0]       shift_r;
  logic [CNT_W-1:0]       bit_cnt;

  // Resynchronize all three pins through equal-depth chains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_sync <= '0;
      st_sync <= '0;
      ds_sync <= '0;
    end else begin
      sh_sync <= {sh_sync[SYNC_STAGES-2:0], sh_cp};
      st_sync <= {st_sync[SYNC_STAGES-2:0], st_cp};
      ds_sync <= {ds_sync[SYNC_STAGES-2:0], ds};
    end
  end

  // Previous-value registers always track, even while disabled, so that
  // raising en never produces an edge from stale history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_prev <= 1'b0;
      st_prev <= 1'b0;
    end else begin
      sh_prev <= sh_s;
      st_prev <= st_s;
    end
  end

  // ---- edge-detect stage: synchronized values vs. previous ----
  assign sh_s    = sh_sync[SYNC_STAGES-1];
  assign st_s    = st_sync[SYNC_STAGES-1];
  assign ds_s    = ds_sync[SYNC_STAGES-1];
  assign sh_rise = sh_s & ~sh_prev;
  assign st_rise = st_s & ~st_prev;

  // Shift, count and latch. On a same-cycle shift and latch, the latch takes
  // the pre-shift word and the new bit is counted against the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r    <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      data_valid <= 1'b0;
      if (!en) begin
        bit_cnt <= '0;
      end else begin
        if (sh_rise) begin
          shift_r <= {shift_r[WIDTH-2:0], ds_s};
        end
        if (st_rise) begin
          data_out   <= shift_r;
          data_valid <= 1'b1;
          frame_err  <= (bit_cnt != FRAME_LEN);
          frame_cnt  <= frame_cnt + 8'd1;
          bit_cnt    <= sh_rise ? CNT_W'(1) : '0;
        end else if (sh_rise && (bit_cnt != CNT_MAX)) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hc595_receiver.sv
// tb_hc595_receiver: directed and randomized frames driven at pin level,
// checked against a stream-level model (the bits received since reset and
// the count of bits since the last latch).
module tb_hc595_receiver;

  localparam int W = 16;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic         sh_cp = 1'b0;
  logic         st_cp = 1'b0;
  logic         ds = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         frame_err;
  logic [7:0]   frame_cnt;

  hc595_receiver #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .sh_cp      (sh_cp),
    .st_cp      (st_cp),
    .ds         (ds),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #10 clk = ~clk;

  int cmp = 0;
  int mis = 0;
  int dv_total = 0;
  int dv_exp = 0;

  // Reference model state.
  bit           q[$];
  int           cnt = 0;
  int           fcnt = 0;
  logic [W-1:0] last_data = '0;

  always @(negedge clk) if (data_valid) dv_total++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word the receiver should hold: the last W bits received, zero-filled.
  function automatic logic [W-1:0] model_word();
    logic [W-1:0] r = '0;
    for (int k = 0; k < W; k++)
      if (q.size() > k) r[k] = q[q.size() - 1 - k];
    return r;
  endfunction

  function automatic void model_push(input bit b);
    q.push_back(b);
    if (q.size() > W) void'(q.pop_front());
  endfunction

  // One sh_cp pulse: ds changes with the previous fall, 2-clk phases.
  task automatic shift_bit(input bit b);
    ds = b;
    repeat (2) @(negedge clk);
    sh_cp = 1'b1;
    repeat (2) @(negedge clk);
    sh_cp = 1'b0;
    if (en) begin
      model_push(b);
      cnt++;
    end
  endtask

  task automatic send_word(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
  endtask

  // One st_cp pulse, optionally with a simultaneous sh_cp pulse carrying b.
  task automatic latch(input bit with_sh, input bit b);
    logic [W-1:0] ew;
    bit           ee;
    int           seen = 0;
    logic [W-1:0] od = '0;
    logic         oe = 1'b0;
    logic [7:0]   oc = '0;
    ds = b;
    repeat (2) @(negedge clk);
    ew = model_word();
    ee = (cnt != W);
    st_cp = 1'b1;
    if (with_sh) sh_cp = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        st_cp = 1'b0;
        sh_cp = 1'b0;
      end
      if (data_valid) begin
        seen++;
        od = data_out;
        oe = frame_err;
        oc = frame_cnt;
      end
    end
    if (en) begin
      fcnt++;
      dv_exp++;
      chk("dv_pulse_count", seen, 1);
      if (seen > 0) begin
        chk("data_out", od, ew);
        chk("frame_err", oe, ee);
        chk("frame_cnt", oc, fcnt & 255);
      end
      last_data = ew;
      if (with_sh) begin
        model_push(b);
        cnt = 1;
      end else begin
        cnt = 0;
      end
    end else begin
      chk("dv_gated", seen, 0);
      chk("dout_hold", data_out, last_data);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    q.delete();
    cnt = 0;
    fcnt = 0;
    last_data = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int base;
    logic [31:0] v;
    int n;
    bit sim;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("init_data_out", data_out, 0);
    chk("init_data_valid", data_valid, 0);
    chk("init_frame_err", frame_err, 0);
    chk("init_frame_cnt", frame_cnt, 0);
    reset_n = 1'b1;
    en = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback-style repeated frames.
    for (int i = 0; i < 3; i++) begin
      send_word(32'hA5C3, 16);
      latch(1'b0, 1'b0);
      chk("loop_word", data_out, 32'hA5C3);
      chk("loop_err", frame_err, 0);
      chk("loop_cnt", frame_cnt, i + 1);
    end

    // Short frame: low 12 bits all ones, upper bits prior contents.
    send_word(32'hFFF, 12);
    latch(1'b0, 1'b0);
    chk("short_low12", data_out[11:0], 32'hFFF);
    chk("short_upper", data_out[15:12], 32'h3);
    chk("short_err", frame_err, 1);

    // Long frame: only the last 16 bits survive.
    send_word(32'h12345, 20);
    latch(1'b0, 1'b0);
    chk("long_word", data_out, 32'h2345);
    chk("long_err", frame_err, 1);

    // Simultaneous shift and latch.
    send_word(32'h8001, 16);
    latch(1'b1, 1'b1);
    chk("simul_word", data_out, 32'h8001);
    send_word($urandom, 15);
    latch(1'b0, 1'b0);
    chk("simul_next_err", frame_err, 0);

    // Enable gating.
    en = 1'b0;
    cnt = 0;
    base = dv_total;
    send_word(32'hFFFF, 16);
    latch(1'b0, 1'b0);
    chk("gated_no_dv", dv_total - base, 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    send_word($urandom, 16);
    latch(1'b0, 1'b0);
    chk("after_gate_err", frame_err, 0);

    // Reset mid-frame.
    send_word($urandom, 8);
    pulse_reset();
    send_word($urandom, 8);
    latch(1'b0, 1'b0);
    chk("post_reset_err", frame_err, 1);

    // Randomized frames: random length, data, gating and simultaneous edges.
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      n = $urandom_range(0, 20);
      sim = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        en = 1'b0;
        cnt = 0;
      end else begin
        en = 1'b1;
      end
      send_word(v, n);
      latch(sim, v[31]);
    end
    en = 1'b1;
    repeat (2) @(negedge clk);

    // Counter wrap.
    pulse_reset();
    base = dv_total;
    for (int i = 0; i < 256; i++) begin
      send_word($urandom, 16);
      latch(1'b0, 1'b0);
    end
    chk("wrap_frame_cnt", frame_cnt, 0);
    chk("wrap_dv_count", dv_total - base, 256);

    repeat (4) @(negedge clk);
    chk("total_dv_count", dv_total, dv_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
